// File: rtl/kb_pkg.sv
// Shared constants and types for the keyboard event scheduler: PS/2 prefix and
// discard bytes, parser states, the queued event layout and default port map.
package kb_pkg;

    localparam logic [7:0] BYTE_EXT    = 8'hE0;
    localparam logic [7:0] BYTE_BRK    = 8'hF0;
    localparam logic [7:0] BYTE_BAT    = 8'hAA;
    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_ECHO   = 8'hEE;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;

    localparam logic [7:0] DEF_PORT_STATUS = 8'h10;
    localparam logic [7:0] DEF_PORT_FLAGS  = 8'h11;
    localparam logic [7:0] DEF_PORT_CODE   = 8'h12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    localparam int EVENT_W = $bits(key_event_t);

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == BYTE_EXT) || (b == BYTE_BRK);
    endfunction

    // Controller replies (BAT pass, ACK, echo, resend) are not key events.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == BYTE_BAT) || (b == BYTE_ACK) || (b == BYTE_ECHO) || (b == BYTE_RESEND);
    endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Small synchronous FIFO for key events; a push into a full FIFO only lands
// when a pop frees the slot in the same cycle.
module kb_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        count_next = count + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/kb_event_scheduler.sv
// PS/2 scan-code parser feeding a key-event FIFO, served to the PicoBlaze
// through status, flags and code input ports.
//
// state      | meaning
// -----------+------------------------------------------
// ST_IDLE    | waiting for the first byte of an event
// ST_EXT     | E0 seen, expecting F0 or the key code
// ST_BRK     | F0 seen, expecting the key code
// ST_EXT_BRK | E0 F0 seen, expecting the key code
module kb_event_scheduler
    import kb_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] PORT_STATUS    = DEF_PORT_STATUS,
    parameter logic [7:0] PORT_FLAGS     = DEF_PORT_FLAGS,
    parameter logic [7:0] PORT_CODE      = DEF_PORT_CODE
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Scan_Byte,
    input  logic       Scan_Valid,
    input  logic [7:0] Port_ID,
    input  logic       Read_Strobe,
    output logic [7:0] Keyboard_Output,
    output logic       Event_Pending
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    parse_state_t  state;
    parse_state_t  state_next;
    parse_state_t  eff_state;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    logic          push_req;
    key_event_t    push_evt;
    logic          push_q;
    key_event_t    push_evt_q;

    logic          rs_q;
    logic          rs_rise;
    logic          pop;
    logic          ovf;
    logic          overflow;

    key_event_t    head_evt;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [4:0]    count_w;
    logic [2:0]    count_sat;

    assign timeout = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            to_cnt     <= '0;
            push_q     <= 1'b0;
            push_evt_q <= '0;
            rs_q       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_next;
            push_q     <= push_req;
            push_evt_q <= push_evt;
            rs_q       <= Read_Strobe;
            if (Scan_Valid || state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (!timeout) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (overflow) begin
                ovf <= 1'b1;
            end else if (rs_rise && Port_ID == PORT_STATUS) begin
                ovf <= 1'b0;
            end
        end
    end

    // A byte arriving on the timeout cycle is parsed as the start of a new event.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        push_evt   = '{ext: 1'b0, brk: 1'b0, code: Scan_Byte};
        eff_state  = timeout ? ST_IDLE : state;
        if (timeout) state_next = ST_IDLE;
        if (Scan_Valid) begin
            state_next = ST_IDLE;
            case (eff_state)
                ST_IDLE: begin
                    if (Scan_Byte == BYTE_EXT) begin
                        state_next = ST_EXT;
                    end else if (Scan_Byte == BYTE_BRK) begin
                        state_next = ST_BRK;
                    end else if (!is_discard(Scan_Byte)) begin
                        push_req = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (Scan_Byte == BYTE_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (Scan_Byte == BYTE_EXT) begin
                        state_next = ST_EXT;
                    end else begin
                        push_req     = 1'b1;
                        push_evt.ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (!is_prefix(Scan_Byte)) begin
                        push_req     = 1'b1;
                        push_evt.brk = 1'b1;
                    end
                end
                ST_EXT_BRK: begin
                    if (!is_prefix(Scan_Byte)) begin
                        push_req     = 1'b1;
                        push_evt.ext = 1'b1;
                        push_evt.brk = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign rs_rise  = Read_Strobe && !rs_q;
    assign pop      = rs_rise && (Port_ID == PORT_CODE) && !fifo_empty;
    assign overflow = push_q && fifo_full && !pop;

    kb_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVENT_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (push_q),
        .push_data (push_evt_q),
        .pop       (pop),
        .head      (head_evt),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign count_w   = 5'(fifo_count);
    assign count_sat = (count_w > 5'd7) ? 3'd7 : count_w[2:0];

    always_comb begin
        Keyboard_Output = 8'h00;
        if (Port_ID == PORT_STATUS) begin
            Keyboard_Output = {2'b00, ovf, count_sat, fifo_full, ~fifo_empty};
        end else if (Port_ID == PORT_FLAGS) begin
            Keyboard_Output = fifo_empty ? 8'h00 : {6'b0, head_evt.brk, head_evt.ext};
        end else if (Port_ID == PORT_CODE) begin
            Keyboard_Output = fifo_empty ? 8'h00 : head_evt.code;
        end
    end

    assign Event_Pending = ~fifo_empty;

endmodule

// File: tb/tb_kb_event_scheduler.sv
// Directed bench for kb_event_scheduler: stimulus queues expected port reads,
// a negedge monitor pops and compares them against the CPU-facing outputs.
module tb_kb_event_scheduler;

    localparam int         T        = 20;
    localparam logic [7:0] P_STATUS = 8'h10;
    localparam logic [7:0] P_FLAGS  = 8'h11;
    localparam logic [7:0] P_CODE   = 8'h12;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] Scan_Byte = 8'h00;
    logic       Scan_Valid = 1'b0;
    logic [7:0] Port_ID = 8'h00;
    logic       Read_Strobe = 1'b0;
    logic [7:0] Keyboard_Output;
    logic       Event_Pending;

    logic [7:0] exp_q[$];
    logic       ep_q[$];
    string      name_q[$];
    logic [7:0] m_kbo;
    logic       m_ep;
    string      m_name;
    logic       mon_en = 1'b0;
    logic       end_chk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    kb_event_scheduler #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .Scan_Byte       (Scan_Byte),
        .Scan_Valid      (Scan_Valid),
        .Port_ID         (Port_ID),
        .Read_Strobe     (Read_Strobe),
        .Keyboard_Output (Keyboard_Output),
        .Event_Pending   (Event_Pending)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: output sampled, got %h, no expectation queued", Keyboard_Output);
            end else begin
                m_kbo  = exp_q.pop_front();
                m_ep   = ep_q.pop_front();
                m_name = name_q.pop_front();
                checks++;
                if (Keyboard_Output !== m_kbo) begin
                    errors++;
                    $display("FAIL %s data: got %h expected %h", m_name, Keyboard_Output, m_kbo);
                end
                checks++;
                if (Event_Pending !== m_ep) begin
                    errors++;
                    $display("FAIL %s pending: got %b expected %b", m_name, Event_Pending, m_ep);
                end
            end
        end
        if (end_chk) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic expect_out(input string n, input logic [7:0] v, input logic ep);
        name_q.push_back(n);
        exp_q.push_back(v);
        ep_q.push_back(ep);
    endtask

    task automatic send_raw(input logic [7:0] b);
        Scan_Byte  = b;
        Scan_Valid = 1'b1;
        tick();
        Scan_Valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_raw(b);
        tick();
    endtask

    task automatic peek(input string n, input logic [7:0] port, input logic [7:0] v, input logic ep);
        Port_ID = port;
        expect_out(n, v, ep);
        mon_en = 1'b1;
        tick();
        mon_en = 1'b0;
    endtask

    task automatic rd(input string n, input logic [7:0] port, input logic [7:0] v, input logic ep);
        Port_ID     = port;
        Read_Strobe = 1'b1;
        expect_out(n, v, ep);
        mon_en = 1'b1;
        tick();
        Read_Strobe = 1'b0;
        mon_en      = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        peek("reset_status", P_STATUS, 8'h00, 1'b0);
        RESET = 1'b1;
        tick();

        // make then break of the same key
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        rd("two_ev_status", P_STATUS, 8'h09, 1'b1);
        rd("make_flags", P_FLAGS, 8'h00, 1'b1);
        rd("make_code", P_CODE, 8'h1C, 1'b1);
        rd("break_flags", P_FLAGS, 8'h02, 1'b1);
        rd("break_code", P_CODE, 8'h1C, 1'b1);
        rd("drained_status", P_STATUS, 8'h00, 1'b0);

        // extended break, pending drops right after the popping edge
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        rd("extbrk_flags", P_FLAGS, 8'h03, 1'b1);
        Port_ID     = P_CODE;
        Read_Strobe = 1'b1;
        expect_out("extbrk_code", 8'h75, 1'b1);
        mon_en = 1'b1;
        tick();
        Read_Strobe = 1'b0;
        expect_out("pending_fall", 8'h00, 1'b0);
        tick();
        mon_en = 1'b0;
        tick();

        // overflow with depth 4
        send(8'h15);
        send(8'h1D);
        send(8'h24);
        send(8'h2D);
        send(8'h2C);
        rd("ovf_status", P_STATUS, 8'h33, 1'b1);
        rd("ovf_cleared", P_STATUS, 8'h13, 1'b1);
        rd("ovf_code0", P_CODE, 8'h15, 1'b1);
        rd("ovf_code1", P_CODE, 8'h1D, 1'b1);
        rd("ovf_code2", P_CODE, 8'h24, 1'b1);
        rd("ovf_code3", P_CODE, 8'h2D, 1'b1);
        rd("ovf_drained", P_STATUS, 8'h00, 1'b0);

        // one cycle short of the timeout keeps the extended prefix
        send_raw(8'hE0);
        idle(T - 1);
        send(8'h1C);
        rd("pre_to_flags", P_FLAGS, 8'h01, 1'b1);
        rd("pre_to_code", P_CODE, 8'h1C, 1'b1);
        // exactly the timeout abandons it
        send_raw(8'hE0);
        idle(T);
        send(8'h1C);
        rd("to_flags", P_FLAGS, 8'h00, 1'b1);
        rd("to_code", P_CODE, 8'h1C, 1'b1);

        // held strobe pops once
        send(8'h1C);
        send(8'h32);
        Port_ID     = P_CODE;
        Read_Strobe = 1'b1;
        expect_out("hold_first", 8'h1C, 1'b1);
        mon_en = 1'b1;
        tick();
        expect_out("hold_second", 8'h32, 1'b1);
        tick();
        expect_out("hold_third", 8'h32, 1'b1);
        tick();
        Read_Strobe = 1'b0;
        mon_en      = 1'b0;
        tick();
        peek("hold_status", P_STATUS, 8'h05, 1'b1);
        rd("hold_code", P_CODE, 8'h32, 1'b1);
        peek("hold_drained", P_STATUS, 8'h00, 1'b0);

        // full FIFO, push and pop in the same cycle
        send(8'h41);
        send(8'h42);
        send(8'h43);
        send(8'h44);
        Scan_Byte  = 8'h45;
        Scan_Valid = 1'b1;
        tick();
        Scan_Valid  = 1'b0;
        Port_ID     = P_CODE;
        Read_Strobe = 1'b1;
        expect_out("pushpop_head", 8'h41, 1'b1);
        mon_en = 1'b1;
        tick();
        Read_Strobe = 1'b0;
        mon_en      = 1'b0;
        tick();
        peek("pushpop_status", P_STATUS, 8'h13, 1'b1);
        rd("pushpop_code0", P_CODE, 8'h42, 1'b1);
        rd("pushpop_code1", P_CODE, 8'h43, 1'b1);
        rd("pushpop_code2", P_CODE, 8'h44, 1'b1);
        rd("pushpop_code3", P_CODE, 8'h45, 1'b1);
        peek("pushpop_drained", P_STATUS, 8'h00, 1'b0);

        // controller replies produce nothing
        send(8'hAA);
        send(8'hFA);
        send(8'hEE);
        send(8'hFE);
        peek("discard_status", P_STATUS, 8'h00, 1'b0);
        peek("other_port", 8'h33, 8'h00, 1'b0);

        // reset mid-sequence
        send(8'h11);
        send(8'hF0);
        RESET = 1'b0;
        tick();
        peek("midreset_status", P_STATUS, 8'h00, 1'b0);
        RESET = 1'b1;
        tick();
        send(8'h1C);
        rd("post_reset_flags", P_FLAGS, 8'h00, 1'b1);
        rd("post_reset_code", P_CODE, 8'h1C, 1'b1);
        peek("post_reset_drained", P_STATUS, 8'h00, 1'b0);

        end_chk = 1'b1;
        tick();
        end_chk = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
